dca_matrix_load_unpacker: RTL and testbench
===========================================

# dca_matrix_load_unpacker

Registered load-path unpacker between the AXI read-response side of the DCA matrix LSU and the LSU element-row consumer. It accepts one memory beat that carries up to MAX_ROW_PER_BEAT packed matrix rows of 1/2/4/8/16/32-bit elements. It emits those rows one per cycle as sign- or zero-extended LSU element rows, with per-column masking and full valid/ready backpressure.

## Interface
- MATRIX_NUM_COL, 4, elements per matrix row
- BW_LSU_ELEMENT, 32, output element width
- MAX_BW_MEMORY_SINGLE, 32, widest memory element; BW_BEAT = MAX_BW_MEMORY_SINGLE*MATRIX_NUM_COL
- MAX_ROW_PER_BEAT, 4, upper bound on rows packed in one beat (power of 2)
- BW_TXN_INFO, 8, opaque transaction tag width
- clk  in  1  clock
- rstnn  in  1  reset, asynchronous, active-low
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data  in  BW_BEAT  packed rows; element c of row k at bits [(k*MATRIX_NUM_COL+c)*ew +: ew], ew = 1<<elem_log2
- in_elem_log2  in  3  element width code 0..5; 6,7 treated as 5
- in_is_signed  in  1  sign-extend when 1
- in_col_mask  in  MATRIX_NUM_COL  column enable
- in_num_row_m1  in  clog2(MAX_ROW_PER_BEAT)  rows in beat minus 1
- in_txn_info  in  BW_TXN_INFO  tag, carried with every output row
- out_valid  out  1  row valid
- out_ready  in  1  row consumed when out_valid && out_ready
- out_row  out  MATRIX_NUM_COL*BW_LSU_ELEMENT  extended elements, column 0 in LSBs
- out_last  out  1  final row of current beat
- out_txn_info  out  BW_TXN_INFO  tag of current beat

## Operation
- The beat register captures in_data, elem_log2, is_signed, col_mask, txn_info and the effective row count on accept.
- Effective rows R = min(in_num_row_m1+1, BW_BEAT/(MATRIX_NUM_COL*ew), MAX_ROW_PER_BEAT). Excess rows are silently clamped.
- States: IDLE (no beat held) and EMIT (beat held, row_idx 0..R-1).
- IDLE: in_ready=1. Accept moves to EMIT with row_idx=0.
- EMIT: out_valid=1 and out_row is row row_idx of the held beat. On out_ready:
  - if row_idx<R-1, row_idx increments;
  - else the beat is done.
- in_ready=1 in EMIT only when out_last && out_ready. A simultaneous accept loads the new beat with row_idx=0 and stays in EMIT. Otherwise the FSM returns to IDLE.
- Extension: ew=1 is always zero-extended. ew≥2 is sign-extended if is_signed, else zero-extended. If ew>BW_LSU_ELEMENT, the low bits are kept.
- out_last = (row_idx == R-1) while in EMIT.

## Timing
- Reset values: out_valid=0, out_last=0, out_row=0, out_txn_info=0, row_idx=0, state IDLE, in_ready=1.
- Latency: beat accepted at edge N gives row 0 visible from N+1.
- Throughput: one row per cycle under continuous out_ready. Back-to-back single-row beats run bubble-free.
- out_row and out_txn_info are stable while out_valid && !out_ready.
- in_ready depends combinationally on out_ready. There is no other combinational in-to-out path.
- Asynchronous reset mid-beat discards the held beat and any remaining rows.

## Configuration
- DCA_LOAD_UNPACKER_COL_MASK_EN defined: output elements whose in_col_mask bit is 0 are forced to 0.
- Undefined: in_col_mask is ignored and not registered, and all columns pass. The port remains present in both builds.

## Structure
- Shared header dca_load_unpacker.vh holds:
  - element width codes (ELEM_LOG2_1B..32B);
  - the clamp value 5;
  - width macros for in_elem_log2 and the row-count field.
- One sub-module, dca_element_extender: a single element with ew select, signedness and mask enable. It is instantiated MATRIX_NUM_COL times in a generate loop.
- The top level holds the FSM, the beat register, the row counter and the row-slice mux.

## Test plan
- 8-bit signed beat, num_row_m1=3, data 0x80FF017F_… , out_ready=1: four rows on consecutive cycles, row 0 elements = 0x0000007F, 0x00000001, 0xFFFFFFFF, 0xFFFFFF80, and out_last only on row 3.
- 4-bit unsigned beat with element 0xF: output element is 0x0000000F. The same beat with is_signed=1 gives 0xFFFFFFFF.
- 32-bit beat with num_row_m1=3: R clamped to 1, one row emitted, out_last=1.
- out_ready held low for 5 cycles mid-beat: out_row and out_txn_info are unchanged, in_ready=0, and no row is skipped afterward.
- Single-row beats streamed with out_ready=1: out_valid stays high each cycle and txn_info sequence 1,2,3 appears in order. Reset asserted while row 1 of 4 is pending: out_valid=0 immediately and in_ready=1.
- COL_MASK_EN build, col_mask=4'b0101: columns 1 and 3 are 0. The build without the macro passes all columns for the same stimulus.

Source files
------------

// File: rtl/dca_matrix_load_unpacker_pkg.sv
// Shared definitions for the DCA matrix load unpacker: element width codes,
// the width-code clamp and field-width helpers.
package dca_matrix_load_unpacker_pkg;

    localparam int unsigned ELEM_LOG2_W = 3;

    typedef enum logic [ELEM_LOG2_W-1:0] {
        ELEM_LOG2_1B  = 3'd0,
        ELEM_LOG2_2B  = 3'd1,
        ELEM_LOG2_4B  = 3'd2,
        ELEM_LOG2_8B  = 3'd3,
        ELEM_LOG2_16B = 3'd4,
        ELEM_LOG2_32B = 3'd5
    } elem_log2_e;

    localparam logic [ELEM_LOG2_W-1:0] ELEM_LOG2_CLAMP = ELEM_LOG2_32B;

    function automatic int unsigned row_cnt_w(int unsigned max_rows);
        return (max_rows > 1) ? $clog2(max_rows) : 1;
    endfunction

    // Codes 6 and 7 are treated as the widest element.
    function automatic logic [ELEM_LOG2_W-1:0] clamp_elem_log2(logic [ELEM_LOG2_W-1:0] code);
        return (code > ELEM_LOG2_CLAMP) ? ELEM_LOG2_CLAMP : code;
    endfunction

endpackage

// File: rtl/dca_element_extender.sv
// Extends one packed element of width 1<<elem_log2 to BW_OUT bits; 1-bit
// elements are always zero-extended, and a cleared enable forces zero.
module dca_element_extender
    import dca_matrix_load_unpacker_pkg::*;
#(
    parameter int unsigned BW_IN  = 32,
    parameter int unsigned BW_OUT = 32
) (
    input  logic [BW_IN-1:0]       raw,
    input  logic [ELEM_LOG2_W-1:0] elem_log2,
    input  logic                   is_signed,
    input  logic                   enable,
    output logic [BW_OUT-1:0]      elem
);

    localparam int unsigned BW_EXT = (BW_IN > BW_OUT) ? BW_IN : BW_OUT;
    localparam int unsigned IDX_W  = (BW_EXT > 1) ? $clog2(BW_EXT) : 1;

    logic [BW_EXT-1:0] raw_ext;
    logic [IDX_W-1:0]  sign_idx;
    logic              sign;
    int unsigned       ew;

    always_comb begin
        raw_ext  = BW_EXT'(raw);
        ew       = 32'd1 << elem_log2;
        sign_idx = IDX_W'(ew - 1);
        sign     = is_signed && (elem_log2 != ELEM_LOG2_1B) && raw_ext[sign_idx];
        elem     = '0;
        for (int unsigned i = 0; i < BW_OUT; i++) begin
            elem[i] = (i < ew) ? raw_ext[i] : sign;
        end
        if (!enable) begin
            elem = '0;
        end
    end

endmodule

// File: rtl/dca_matrix_load_unpacker.sv
// Unpacks one memory beat of packed matrix rows into extended LSU rows, one per
// cycle. Define DCA_LOAD_UNPACKER_COL_MASK_EN to zero masked-off columns.
module dca_matrix_load_unpacker
    import dca_matrix_load_unpacker_pkg::*;
#(
    parameter int unsigned MATRIX_NUM_COL       = 4,
    parameter int unsigned BW_LSU_ELEMENT       = 32,
    parameter int unsigned MAX_BW_MEMORY_SINGLE = 32,
    parameter int unsigned MAX_ROW_PER_BEAT     = 4,
    parameter int unsigned BW_TXN_INFO          = 8
) (
    input  logic                                          clk,
    input  logic                                          rstnn,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [MAX_BW_MEMORY_SINGLE*MATRIX_NUM_COL-1:0] in_data,
    input  logic [ELEM_LOG2_W-1:0]                        in_elem_log2,
    input  logic                                          in_is_signed,
    input  logic [MATRIX_NUM_COL-1:0]                     in_col_mask,
    input  logic [row_cnt_w(MAX_ROW_PER_BEAT)-1:0]        in_num_row_m1,
    input  logic [BW_TXN_INFO-1:0]                        in_txn_info,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [MATRIX_NUM_COL*BW_LSU_ELEMENT-1:0]      out_row,
    output logic                                          out_last,
    output logic [BW_TXN_INFO-1:0]                        out_txn_info
);

    localparam int unsigned BW_BEAT = MAX_BW_MEMORY_SINGLE * MATRIX_NUM_COL;
    localparam int unsigned RCW     = row_cnt_w(MAX_ROW_PER_BEAT);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [RCW-1:0]         row_idx_q, row_idx_d;
    logic [RCW-1:0]         rows_m1_q, rows_m1_in;
    logic [BW_BEAT-1:0]     data_q;
    logic [ELEM_LOG2_W-1:0] elem_log2_q, elem_log2_in;
    logic                   is_signed_q;
    logic [BW_TXN_INFO-1:0] txn_info_q;
    logic [MATRIX_NUM_COL-1:0] col_en;
    logic [MATRIX_NUM_COL*BW_LSU_ELEMENT-1:0] row_ext;
    logic                   accept;
    int unsigned            rows_fit, rows_eff;

`ifdef DCA_LOAD_UNPACKER_COL_MASK_EN
    logic [MATRIX_NUM_COL-1:0] col_mask_q;
    assign col_en = col_mask_q;
`else
    logic unused_col_mask;
    assign unused_col_mask = ^in_col_mask;
    assign col_en = '1;
`endif

    // Effective row count: requested, capacity of the beat at this width, hard limit.
    always_comb begin
        elem_log2_in = clamp_elem_log2(in_elem_log2);
        rows_fit     = MAX_BW_MEMORY_SINGLE >> elem_log2_in;
        rows_eff     = 32'(in_num_row_m1) + 1;
        if (rows_eff > rows_fit)         rows_eff = rows_fit;
        if (rows_eff > MAX_ROW_PER_BEAT) rows_eff = MAX_ROW_PER_BEAT;
        if (rows_eff == 0)               rows_eff = 1;
        rows_m1_in = RCW'(rows_eff - 1);
    end

    assign out_valid = (state_q == ST_EMIT);
    assign out_last  = out_valid && (row_idx_q == rows_m1_q);
    assign in_ready  = (state_q == ST_IDLE) || (out_last && out_ready);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        if (accept) begin
            state_d   = ST_EMIT;
            row_idx_d = '0;
        end else if (out_valid && out_ready) begin
            if (out_last) begin
                state_d   = ST_IDLE;
                row_idx_d = '0;
            end else begin
                row_idx_d = row_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q     <= ST_IDLE;
            row_idx_q   <= '0;
            rows_m1_q   <= '0;
            data_q      <= '0;
            elem_log2_q <= '0;
            is_signed_q <= 1'b0;
            txn_info_q  <= '0;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            if (accept) begin
                rows_m1_q   <= rows_m1_in;
                data_q      <= in_data;
                elem_log2_q <= elem_log2_in;
                is_signed_q <= in_is_signed;
                txn_info_q  <= in_txn_info;
            end
        end
    end

`ifdef DCA_LOAD_UNPACKER_COL_MASK_EN
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            col_mask_q <= '0;
        end else if (accept) begin
            col_mask_q <= in_col_mask;
        end
    end
`endif

    for (genvar c = 0; c < MATRIX_NUM_COL; c++) begin : g_col
        logic [BW_BEAT-1:0]              shifted;
        logic [MAX_BW_MEMORY_SINGLE-1:0] raw;
        int unsigned                     bit_ofs;

        always_comb begin
            bit_ofs = (32'(row_idx_q) * MATRIX_NUM_COL + 32'(c)) << elem_log2_q;
            shifted = data_q >> bit_ofs;
            raw     = shifted[MAX_BW_MEMORY_SINGLE-1:0];
        end

        dca_element_extender #(
            .BW_IN  (MAX_BW_MEMORY_SINGLE),
            .BW_OUT (BW_LSU_ELEMENT)
        ) u_ext (
            .raw       (raw),
            .elem_log2 (elem_log2_q),
            .is_signed (is_signed_q),
            .enable    (col_en[c]),
            .elem      (row_ext[c*BW_LSU_ELEMENT +: BW_LSU_ELEMENT])
        );
    end

    assign out_row      = out_valid ? row_ext : '0;
    assign out_txn_info = out_valid ? txn_info_q : '0;

endmodule

// File: tb/tb_dca_matrix_load_unpacker.sv
// Directed, table-driven bench for dca_matrix_load_unpacker (4 cols x 32 bits);
// expectations follow DCA_LOAD_UNPACKER_COL_MASK_EN when it is defined.
module tb_dca_matrix_load_unpacker;

    logic         clk;
    logic         rstnn;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [2:0]   in_elem_log2;
    logic         in_is_signed;
    logic [3:0]   in_col_mask;
    logic [1:0]   in_num_row_m1;
    logic [7:0]   in_txn_info;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_row;
    logic         out_last;
    logic [7:0]   out_txn_info;

    dca_matrix_load_unpacker dut (
        .clk           (clk),
        .rstnn         (rstnn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_elem_log2  (in_elem_log2),
        .in_is_signed  (in_is_signed),
        .in_col_mask   (in_col_mask),
        .in_num_row_m1 (in_num_row_m1),
        .in_txn_info   (in_txn_info),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_row       (out_row),
        .out_last      (out_last),
        .out_txn_info  (out_txn_info)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       el;
        logic             sgn;
        logic [3:0]       mask;
        logic [1:0]       nrm1;
        logic [7:0]       txn;
        logic [127:0]     data;
        int               nrows;
        logic [3:0][127:0] rows;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];
    vec_t v;
    int   n_vec;
    int   n_err;

    function automatic logic [127:0] row4(logic [31:0] e3, logic [31:0] e2,
                                          logic [31:0] e1, logic [31:0] e0);
        return {e3, e2, e1, e0};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t b);
        in_data       = b.data;
        in_elem_log2  = b.el;
        in_is_signed  = b.sgn;
        in_col_mask   = b.mask;
        in_num_row_m1 = b.nrm1;
        in_txn_info   = b.txn;
    endtask

    // Presents a beat on a negedge and leaves in_valid low after the accepting edge.
    task automatic apply(input vec_t b, input string name);
        @(negedge clk);
        drive(b);
        in_valid = 1'b1;
        chk({name, " in_ready before accept"}, 128'(in_ready), 128'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        vecs[0] = '{3'd3, 1'b1, 4'hF, 2'd3, 8'h11,
                    {32'h0, 32'hDEADBEEF, 32'h12345678, 32'h80FF017F}, 4,
                    {128'h0,
                     row4(32'hFFFFFFDE, 32'hFFFFFFAD, 32'hFFFFFFBE, 32'hFFFFFFEF),
                     row4(32'h12, 32'h34, 32'h56, 32'h78),
                     row4(32'hFFFFFF80, 32'hFFFFFFFF, 32'h1, 32'h7F)}};
        vecs[1] = '{3'd2, 1'b0, 4'hF, 2'd0, 8'h21, 128'h178F, 1,
                    {384'h0, row4(32'h1, 32'h7, 32'h8, 32'hF)}};
        vecs[2] = '{3'd2, 1'b1, 4'hF, 2'd0, 8'h22, 128'h178F, 1,
                    {384'h0, row4(32'h1, 32'h7, 32'hFFFFFFF8, 32'hFFFFFFFF)}};
        vecs[3] = '{3'd5, 1'b1, 4'hF, 2'd3, 8'h23,
                    {32'hCAFEF00D, 32'h80000000, 32'h00000001, 32'hFFFFFFFF}, 1,
                    {384'h0, row4(32'hCAFEF00D, 32'h80000000, 32'h1, 32'hFFFFFFFF)}};
        vecs[4] = '{3'd0, 1'b1, 4'hF, 2'd1, 8'h24, 128'h6B, 2,
                    {256'h0, row4(32'h0, 32'h1, 32'h1, 32'h0),
                     row4(32'h1, 32'h0, 32'h1, 32'h1)}};
        vecs[5] = '{3'd4, 1'b1, 4'hF, 2'd3, 8'h25,
                    {64'h0001_7FFF_8000_FFFF, 64'h1234_ABCD_0000_8001}, 2,
                    {256'h0, row4(32'h1, 32'h7FFF, 32'hFFFF8000, 32'hFFFFFFFF),
                     row4(32'h1234, 32'hFFFFABCD, 32'h0, 32'hFFFF8001)}};
        vecs[6] = '{3'd7, 1'b0, 4'hF, 2'd0, 8'h26,
                    {32'h4, 32'h3, 32'h80000002, 32'h89ABCDEF}, 1,
                    {384'h0, row4(32'h4, 32'h3, 32'h80000002, 32'h89ABCDEF)}};
`ifdef DCA_LOAD_UNPACKER_COL_MASK_EN
        vecs[7] = '{3'd3, 1'b0, 4'b0101, 2'd0, 8'h27, 128'h44332211, 1,
                    {384'h0, row4(32'h0, 32'h33, 32'h0, 32'h11)}};
`else
        vecs[7] = '{3'd3, 1'b0, 4'b0101, 2'd0, 8'h27, 128'h44332211, 1,
                    {384'h0, row4(32'h44, 32'h33, 32'h22, 32'h11)}};
`endif
        vecs[8] = '{3'd1, 1'b1, 4'hF, 2'd0, 8'h28, 128'h9C, 1,
                    {384'h0, row4(32'hFFFFFFFE, 32'h1, 32'hFFFFFFFF, 32'h0)}};

        rstnn     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(vecs[0]);
        #2;
        chk("reset out_valid", 128'(out_valid), 128'(0));
        chk("reset out_last", 128'(out_last), 128'(0));
        chk("reset out_row", out_row, 128'h0);
        chk("reset out_txn_info", 128'(out_txn_info), 128'h0);
        chk("reset in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        @(negedge clk);
        rstnn = 1'b1;

        // Table sweep with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
            for (int r = 0; r < vecs[i].nrows; r++) begin
                @(negedge clk);
                chk($sformatf("vec%0d row%0d valid", i, r), 128'(out_valid), 128'(1));
                chk($sformatf("vec%0d row%0d data", i, r), out_row, vecs[i].rows[r]);
                chk($sformatf("vec%0d row%0d last", i, r), 128'(out_last),
                    128'(r == vecs[i].nrows - 1));
                chk($sformatf("vec%0d row%0d txn", i, r), 128'(out_txn_info),
                    128'(vecs[i].txn));
            end
            @(negedge clk);
            chk($sformatf("vec%0d drained", i), 128'(out_valid), 128'(0));
        end

        // Backpressure: five stalled cycles on row 0 with a competing beat offered.
        v = vecs[0];
        v.txn = 8'h5A;
        out_ready = 1'b0;
        apply(v, "stall");
        drive(vecs[3]);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d row", k), out_row, v.rows[0]);
            chk($sformatf("stall%0d txn", k), 128'(out_txn_info), 128'(8'h5A));
            chk($sformatf("stall%0d in_ready", k), 128'(in_ready), 128'(0));
            chk($sformatf("stall%0d valid", k), 128'(out_valid), 128'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int r = 1; r < 4; r++) begin
            @(negedge clk);
            chk($sformatf("after stall row%0d", r), out_row, v.rows[r]);
            chk($sformatf("after stall last%0d", r), 128'(out_last), 128'(r == 3));
        end
        @(negedge clk);
        chk("after stall drained", 128'(out_valid), 128'(0));

        // Back-to-back single-row beats must stream without bubbles.
        v = vecs[3];
        v.txn = 8'd1;
        @(negedge clk);
        drive(v);
        in_valid = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            chk($sformatf("stream%0d valid", t), 128'(out_valid), 128'(1));
            chk($sformatf("stream%0d txn", t), 128'(out_txn_info), 128'(t));
            chk($sformatf("stream%0d last", t), 128'(out_last), 128'(1));
            chk($sformatf("stream%0d in_ready", t), 128'(in_ready), 128'(1));
            v.txn = 8'(t + 1);
            drive(v);
            if (t == 3) in_valid = 1'b0;
        end
        @(negedge clk);
        chk("stream drained", 128'(out_valid), 128'(0));

        // Asynchronous reset with row 1 of 4 pending.
        apply(vecs[0], "rst");
        @(negedge clk);
        chk("rst row0", out_row, vecs[0].rows[0]);
        @(negedge clk);
        chk("rst row1 pending", out_row, vecs[0].rows[1]);
        #1 rstnn = 1'b0;
        #1;
        chk("rst out_valid", 128'(out_valid), 128'(0));
        chk("rst in_ready", 128'(in_ready), 128'(1));
        chk("rst out_row", out_row, 128'h0);
        @(negedge clk);
        rstnn = 1'b1;
        @(negedge clk);
        chk("post rst out_valid", 128'(out_valid), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
